dcm_reset_sequencer: RTL

DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

---
 rtl/dcm_reset_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dcm_reset_sequencer.sv
// Brings a DCM out of reset, waits for a stable lock, then releases the clock28 domain.
// Lock loss retries the DCM up to MAX_RETRIES times before latching a sticky failure.
module dcm_reset_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 15
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       dcmRst,
  output logic       sysReset,
  output logic [2:0] state,
  output logic [3:0] retries,
  output logic       fail
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_DCM = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    retries_reg, retries_next;
  logic          fail_reg, fail_next;
  logic          dcm_rst_reg, dcm_rst_next;
  logic          sys_reset_reg, sys_reset_next;
  logic [1:0]    sync_reg;
  logic          locked_s;
  logic          retry;

  assign locked_s = sync_reg[1];

  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      sync_reg      <= 2'b00;
      state_reg     <= S_RESET_DCM;
      cnt_reg       <= '0;
      retries_reg   <= 4'd0;
      fail_reg      <= 1'b0;
      dcm_rst_reg   <= 1'b1;
      sys_reset_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[0], locked};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retries_reg   <= retries_next;
      fail_reg      <= fail_next;
      dcm_rst_reg   <= dcm_rst_next;
      sys_reset_reg <= sys_reset_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    retries_next = retries_reg;
    fail_next    = fail_reg;
    retry        = 1'b0;

    case (state_reg)
      S_RESET_DCM: if (cnt_reg == RST_LAST) state_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s) state_next = S_STABLE;
        else if (cnt_reg == LOCK_LAST) retry = 1'b1;
      end
      S_STABLE: begin
        if (!locked_s) retry = 1'b1;
        else if (cnt_reg == STABLE_LAST) begin
          state_next   = S_RUN;
          retries_next = 4'd0;
        end
      end
      S_RUN:   if (!locked_s) state_next = S_RESET_DCM;
      S_FAIL:  state_next = S_FAIL;
      default: state_next = S_RESET_DCM;
    endcase

    // The retry budget is checked before incrementing so retries saturates at the limit.
    if (retry) begin
      if (retries_reg == RETRY_LIMIT) begin
        state_next = S_FAIL;
        fail_next  = 1'b1;
      end else begin
        retries_next = retries_reg + 4'd1;
        state_next   = S_RESET_DCM;
      end
    end

    if (restart) begin
      state_next   = S_RESET_DCM;
      retries_next = 4'd0;
      fail_next    = 1'b0;
    end

    // RUN and FAIL are untimed, so the counter idles at zero there.
    if (state_next != state_reg || restart || state_reg == S_RUN || state_reg == S_FAIL)
      cnt_next = '0;

    dcm_rst_next   = (state_next == S_RESET_DCM) || (state_next == S_FAIL);
    sys_reset_next = (state_next != S_RUN);
  end

  assign state    = state_reg;
  assign retries  = retries_reg;
  assign fail     = fail_reg;
  assign dcmRst   = dcm_rst_reg;
  assign sysReset = sys_reset_reg;

endmodule
